mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous data/instruction SRAM between the core's
//  instruction fetch (IF) and load/store (LSU) requesters. Arbitrates per cycle,
//  returns read data one cycle after acceptance, and raises a sticky halt when
//  the program writes 0xFF to the halt byte. Sits between Core pipeline and memory.
// PARAMETERS
//  ADDR_W       16      byte-address width
//  DATA_W       64      data width; strobe width DATA_W/8
//  STARVE_LIMIT 4       consecutive denied IF cycles before IF gets priority (0 = IF always wins)
//  HALT_ADDR    'hFFFC  byte address of halt flag
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous reset, active-high
//  if_req_valid   in   1          IF read request
//  if_req_ready   out  1          IF request accepted this cycle
//  if_req_addr    in   ADDR_W     IF byte address
//  if_rsp_valid   out  1          IF read data valid
//  if_rsp_data    out  DATA_W     IF read data
//  d_req_valid    in   1          LSU request
//  d_req_ready    out  1          LSU request accepted this cycle
//  d_req_we       in   1          1 = write, 0 = read
//  d_req_addr     in   ADDR_W     LSU byte address
//  d_req_wdata    in   DATA_W     write data
//  d_req_wstrb    in   DATA_W/8   byte write enables
//  d_rsp_valid    out  1          LSU read data / write ack valid
//  d_rsp_data     out  DATA_W     LSU read data (0 on write ack)
//  mem_en         out  1          memory access this cycle
//  mem_we         out  DATA_W/8   memory byte write enables
//  mem_addr       out  ADDR_W-3   memory word index = addr[ADDR_W-1:3]
//  mem_wdata      out  DATA_W     memory write data
//  mem_rdata      in   DATA_W     memory read data, valid cycle after mem_en
//  halt           out  1          sticky halt flag
// BEHAVIOUR
//  Reset: all *_ready, *_rsp_valid, mem_en, mem_we, halt = 0; rsp data = 0;
//   starve counter = 0; response owner = NONE. Reset drops any in-flight response.
//  Grant (combinational, one accept per cycle):
//   - only one valid -> it wins; both valid -> LSU wins unless starve_cnt >= STARVE_LIMIT.
//   - halt = 1 -> if_req_ready forced 0; LSU still served.
//   - ready asserted only for the winner and only when its valid is high (no ready-before-valid).
//  Memory drive: mem_en = any accept; mem_addr/mem_wdata from winner;
//   mem_we = d_req_wstrb when LSU write accepted, else 0. Address bits [2:0] ignored.
//  Response FSM (owner register): NONE / IF_RD / D_RD / D_WR.
//   - accept -> owner set for next cycle; no accept -> NONE.
//   - IF_RD: if_rsp_valid = 1, if_rsp_data = mem_rdata.
//   - D_RD: d_rsp_valid = 1, d_rsp_data = mem_rdata.  D_WR: d_rsp_valid = 1, data 0.
//   - latency exactly 1 cycle; back-to-back accepts give back-to-back responses.
//   - no response backpressure: requesters must sink rsp the cycle it is valid.
//  Starve counter: +1 (saturating at STARVE_LIMIT) each cycle if_req_valid && !if_req_ready
//   && !halt; cleared to 0 on IF accept; held when IF idle.
//  Halt: on accepted LSU write with addr[ADDR_W-1:3] == HALT_ADDR[ADDR_W-1:3], strobe
//   bit HALT_ADDR[2:0] set and that byte lane of wdata == 8'hFF -> halt = 1 next cycle,
//   sticky until rst. Other byte values or other lanes do not set it.
//  Simultaneous reset + request: reset wins; nothing accepted that cycle.
// TESTING
//  1 IF-only read 0x0010 -> if_req_ready same cycle, mem_addr=0x002, if_rsp_valid 1 cycle later with mem word.
//  2 IF+LSU valid every cycle, STARVE_LIMIT=4 -> 4 LSU grants, 5th cycle IF grant, counter back to 0, pattern repeats.
//  3 LSU write addr 0x9008 wdata 0x11..88 wstrb 0x0F -> mem_we=0x0F, mem_addr=0x1201, d_rsp_valid next cycle, data 0.
//  4 LSU write 0xFFFC, wstrb 0x10, byte4=0xFF -> halt=1 next cycle; later IF requests never ready; LSU reads still served.
//  5 Same write with byte4=0xFE or wstrb 0x01 -> halt stays 0.
//  6 rst asserted the cycle after a D read accept -> d_rsp_valid=0, halt=0, counter=0 next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and load/store unit.
// One accept per cycle, read data returned one cycle later, sticky halt on halt-byte write.
module mem_port_arbiter #(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 64,
  parameter int                STARVE_LIMIT = 4,
  parameter logic [ADDR_W-1:0] HALT_ADDR    = 'hFFFC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic                d_req_we,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wstrb,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-4:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                halt
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT       = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-4:0] HALT_WORD   = HALT_ADDR[ADDR_W-1:3];
  localparam int                HALT_LANE_I = int'(HALT_ADDR[2:0]);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_DRD  = 2'd2;
  localparam logic [1:0] OWN_DWR  = 2'd3;

  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             halt_q, halt_d;

  logic ifCand, dCand, ifPriority, ifGrant, dGrant, dWrGrant, haltHit;
  logic unusedAddrBits;

  assign unusedAddrBits = ^{if_req_addr[2:0], d_req_addr[2:0]};

  // Reset suppresses every accept; a halted core may no longer fetch.
  always_comb begin
    ifCand     = if_req_valid && !halt_q && !rst;
    dCand      = d_req_valid && !rst;
    ifPriority = (starve_q >= LIMIT);
    ifGrant    = ifCand && (!dCand || ifPriority);
    dGrant     = dCand && !ifGrant;
    dWrGrant   = dGrant && d_req_we;
  end

  assign if_req_ready = ifGrant;
  assign d_req_ready  = dGrant;
  assign mem_en       = ifGrant || dGrant;
  assign mem_addr     = ifGrant ? if_req_addr[ADDR_W-1:3] : d_req_addr[ADDR_W-1:3];
  assign mem_we       = dWrGrant ? d_req_wstrb : '0;
  assign mem_wdata    = dWrGrant ? d_req_wdata : '0;

  assign haltHit = dWrGrant
                && (d_req_addr[ADDR_W-1:3] == HALT_WORD)
                && d_req_wstrb[HALT_LANE_I]
                && (d_req_wdata[HALT_LANE_I*8 +: 8] == 8'hFF);

  always_comb begin
    owner_d = OWN_NONE;
    if (ifGrant) begin
      owner_d = OWN_IF;
    end else if (dGrant) begin
      owner_d = d_req_we ? OWN_DWR : OWN_DRD;
    end
  end

  // Counts cycles an active, non-halted IF request was passed over.
  always_comb begin
    starve_d = starve_q;
    if (ifGrant) begin
      starve_d = '0;
    end else if (if_req_valid && !halt_q && (starve_q < LIMIT)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  assign halt_d = halt_q || haltHit;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
      halt_q   <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
      halt_q   <= halt_d;
    end
  end

  // Gating with rst drops a response already in flight when reset arrives.
  assign if_rsp_valid = (owner_q == OWN_IF) && !rst;
  assign if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
  assign d_rsp_valid  = ((owner_q == OWN_DRD) || (owner_q == OWN_DWR)) && !rst;
  assign d_rsp_data   = ((owner_q == OWN_DRD) && !rst) ? mem_rdata : '0;
  assign halt         = halt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts grants and
// responses, an SRAM model backs the memory port, and a monitor checks the responses.
module tb_mem_port_arbiter;

  localparam int             ADDR_W       = 16;
  localparam int             DATA_W       = 64;
  localparam int             STARVE_LIMIT = 4;
  localparam int             WORDS        = 8192;
  localparam logic [15:0]    HALT_ADDR    = 16'hFFFC;
  localparam logic [12:0]    HALT_WORD    = HALT_ADDR[15:3];
  localparam int             HALT_LANE    = int'(HALT_ADDR[2:0]);

  logic        clk, rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [15:0] if_req_addr;
  logic [63:0] if_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
  logic [15:0] d_req_addr;
  logic [63:0] d_req_wdata, d_rsp_data;
  logic [7:0]  d_req_wstrb;
  logic        mem_en, halt;
  logic [7:0]  mem_we;
  logic [12:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT), .HALT_ADDR(HALT_ADDR)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [63:0] data;
  } rsp_t;

  rsp_t        ifQ[$];
  rsp_t        dQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          starveCnt;
  bit          haltFlag;
  logic [63:0] shadow [WORDS];
  logic [63:0] sram [WORDS];

  function automatic logic [63:0] initWord(int i);
    logic [31:0] k;
    k = 32'(i);
    return {k * 32'h9E3779B1, ~(k * 32'h85EBCA6B)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // SRAM model: port values captured mid-cycle, applied at the next rising edge.
  initial begin
    logic        en;
    logic [7:0]  we;
    logic [12:0] a;
    logic [63:0] wd;
    for (int i = 0; i < WORDS; i++) sram[i] = initWord(i);
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      en = mem_en; we = mem_we; a = mem_addr; wd = mem_wdata;
      @(posedge clk);
      if (en === 1'b1) begin
        mem_rdata = sram[a];
        for (int b = 0; b < 8; b++)
          if (we[b]) sram[a][8*b +: 8] = wd[8*b +: 8];
      end
    end
  end

  // Drives one cycle of requests, checks the request-side outputs and advances the model.
  task automatic applyStimulus(input bit r, input bit ifv, input logic [15:0] ifa,
                               input bit dv, input bit we, input logic [15:0] da,
                               input logic [63:0] wd, input logic [7:0] ws);
    bit   ifOk, dOk, ifWin, dWin;
    int   ifWord, dWord;
    rsp_t e;
    @(posedge clk);
    #1;
    cycle++;
    rst = r; if_req_valid = ifv; if_req_addr = ifa;
    d_req_valid = dv; d_req_we = we; d_req_addr = da; d_req_wdata = wd; d_req_wstrb = ws;
    @(negedge clk);
    ifWord = int'(ifa) / 8;
    dWord  = int'(da) / 8;
    ifOk   = ifv && !haltFlag && !r;
    dOk    = dv && !r;
    ifWin  = ifOk && (!dOk || starveCnt >= STARVE_LIMIT);
    dWin   = dOk && !ifWin;
    checkOutput("ifReqReady", 64'(if_req_ready), 64'(ifWin));
    checkOutput("dReqReady", 64'(d_req_ready), 64'(dWin));
    checkOutput("memEn", 64'(mem_en), 64'(ifWin || dWin));
    checkOutput("memWe", 64'(mem_we), (dWin && we) ? 64'(ws) : 64'd0);
    if (ifWin || dWin) checkOutput("memAddr", 64'(mem_addr), 64'(ifWin ? ifWord : dWord));
    if (dWin && we) checkOutput("memWdata", mem_wdata, wd);
    checkOutput("halt", 64'(halt), 64'(haltFlag));
    if (ifWin) starveCnt = 0;
    else if (ifv && !haltFlag && starveCnt < STARVE_LIMIT) starveCnt++;
    if (ifWin) begin
      e.due = cycle + 1; e.data = shadow[ifWord]; ifQ.push_back(e);
    end
    if (dWin) begin
      e.due = cycle + 1;
      if (we) begin
        e.data = 64'd0;
        for (int b = 0; b < 8; b++)
          if (ws[b]) shadow[dWord][8*b +: 8] = wd[8*b +: 8];
        if (da[15:3] == HALT_WORD && ws[HALT_LANE] && wd[8*HALT_LANE +: 8] == 8'hFF)
          haltFlag = 1'b1;
      end else begin
        e.data = shadow[dWord];
      end
      dQ.push_back(e);
    end
    if (r) begin
      starveCnt = 0;
      haltFlag  = 1'b0;
    end
  endtask

  // Response monitor: any response due this cycle must appear, otherwise none may.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        checkOutput("ifRspDroppedByReset", 64'(if_rsp_valid), 64'd0);
        checkOutput("dRspDroppedByReset", 64'(d_rsp_valid), 64'd0);
        if (ifQ.size() > 0 && ifQ[0].due == cycle) void'(ifQ.pop_front());
        if (dQ.size() > 0 && dQ[0].due == cycle) void'(dQ.pop_front());
      end else begin
        if (ifQ.size() > 0 && ifQ[0].due == cycle) begin
          checkOutput("ifRspValid", 64'(if_rsp_valid), 64'd1);
          checkOutput("ifRspData", if_rsp_data, ifQ[0].data);
          void'(ifQ.pop_front());
        end else begin
          checkOutput("ifRspIdle", 64'(if_rsp_valid), 64'd0);
        end
        if (dQ.size() > 0 && dQ[0].due == cycle) begin
          checkOutput("dRspValid", 64'(d_rsp_valid), 64'd1);
          checkOutput("dRspData", d_rsp_data, dQ[0].data);
          void'(dQ.pop_front());
        end else begin
          checkOutput("dRspIdle", 64'(d_rsp_valid), 64'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] randAddr();
    return {13'h0040 + 13'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
  endfunction

  task automatic randomCycles(input int n, input bit allowReset);
    bit r;
    for (int i = 0; i < n; i++) begin
      r = allowReset && ($urandom_range(0, 49) == 0);
      applyStimulus(r, $urandom_range(0, 2) != 0, randAddr(),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, randAddr(),
                    {$urandom, $urandom}, 8'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    rst = 1'b1; if_req_valid = 1'b0; if_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0; d_req_wstrb = '0;
    starveCnt = 0; haltFlag = 1'b0;
    for (int i = 0; i < WORDS; i++) shadow[i] = initWord(i);

    applyStimulus(1, 0, 16'h0, 0, 0, 16'h0, 64'h0, 8'h0);
    applyStimulus(1, 1, 16'h0010, 1, 0, 16'h0020, 64'h0, 8'h0);
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 64'h0, 8'h0);

    applyStimulus(0, 1, 16'h0010, 0, 0, 16'h0, 64'h0, 8'h0);
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 64'h0, 8'h0);

    for (int i = 0; i < 12; i++)
      applyStimulus(0, 1, 16'h0200 + 16'(8 * i), 1, 0, 16'h0300 + 16'(8 * i), 64'h0, 8'h0);

    applyStimulus(0, 0, 16'h0, 1, 1, 16'h9008, 64'h1122334455667788, 8'h0F);
    applyStimulus(0, 0, 16'h0, 1, 0, 16'h900C, 64'h0, 8'h0);

    applyStimulus(0, 0, 16'h0, 1, 1, 16'hFFFC, 64'h000000FE_00000000, 8'h10);
    applyStimulus(0, 0, 16'h0, 1, 1, 16'hFFFC, 64'h000000FF_000000FF, 8'h01);
    applyStimulus(0, 1, 16'h0040, 0, 0, 16'h0, 64'h0, 8'h0);

    randomCycles(400, 1'b0);

    applyStimulus(0, 0, 16'h0, 1, 1, 16'hFFFC, 64'h000000FF_00000000, 8'h10);
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 1, 16'h0100 + 16'(8 * i), (i % 2) == 0, 0, 16'h9008, 64'h0, 8'h0);

    applyStimulus(0, 0, 16'h0, 1, 0, 16'h0208, 64'h0, 8'h0);
    applyStimulus(1, 1, 16'h0010, 1, 0, 16'h0208, 64'h0, 8'h0);
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 64'h0, 8'h0);
    applyStimulus(0, 1, 16'h0018, 1, 0, 16'h0020, 64'h0, 8'h0);

    randomCycles(120, 1'b1);
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 64'h0, 8'h0);
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 64'h0, 8'h0);

    checkOutput("ifQueueDrained", 64'(ifQ.size()), 64'd0);
    checkOutput("dQueueDrained", 64'(dQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
